// File: rtl/sp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sp_pkg                                                 |
// | Description : Shared types and constants for the StreamProcessor     |
// |               draw scheduler (command record, FSM state encoding).   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package sp_pkg;

    localparam int SP_TEX_W      = 256;
    localparam int SP_X_W        = 4;
    localparam int SP_Z_W        = 8;
    // Command records carry a fixed-width address; the scheduler uses the
    // low TEX_AW bits, so any TEX_AW up to this width is supported.
    localparam int SP_ADDR_MAX_W = 16;

    typedef struct packed {
        logic [SP_ADDR_MAX_W-1:0] tex_addr;
        logic [SP_X_W-1:0]        start_x;
        logic [SP_Z_W-1:0]        z;
        logic                     last;
    } sp_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4,
        ST_CLEAR = 3'd5
    } sp_state_t;

endpackage : sp_pkg
`default_nettype wire

// File: rtl/sp_draw_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : sp_draw_scheduler_if                                   |
// | Description : Command, texture-memory, array-broadcast and status    |
// |               signals of the draw scheduler.                         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface sp_draw_scheduler_if #(
    parameter int TEX_AW = 10
);
    import sp_pkg::*;

    // host command channel
    logic                i_frame_start;
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [TEX_AW-1:0]   i_cmd_tex_addr;
    logic [SP_X_W-1:0]   i_cmd_start_x;
    logic [SP_Z_W-1:0]   i_cmd_z;
    logic                i_cmd_last;
    // texture memory
    logic                o_tex_rd;
    logic [TEX_AW-1:0]   o_tex_addr;
    logic [SP_TEX_W-1:0] i_tex_data;
    // tile array broadcast
    logic                o_sp_reset_n;
    logic                o_sp_ena;
    logic [SP_TEX_W-1:0] o_sp_texture_data;
    logic [SP_X_W-1:0]   o_sp_start_x;
    logic [SP_Z_W-1:0]   o_sp_z;
    // status
    logic                o_busy;
    logic                o_frame_done;

    // Driver side: host plus texture memory
    modport master (
        output i_frame_start, i_cmd_valid, i_cmd_tex_addr, i_cmd_start_x,
               i_cmd_z, i_cmd_last, i_tex_data,
        input  o_cmd_ready, o_tex_rd, o_tex_addr, o_sp_reset_n, o_sp_ena,
               o_sp_texture_data, o_sp_start_x, o_sp_z, o_busy, o_frame_done
    );

    // Scheduler side
    modport slave (
        input  i_frame_start, i_cmd_valid, i_cmd_tex_addr, i_cmd_start_x,
               i_cmd_z, i_cmd_last, i_tex_data,
        output o_cmd_ready, o_tex_rd, o_tex_addr, o_sp_reset_n, o_sp_ena,
               o_sp_texture_data, o_sp_start_x, o_sp_z, o_busy, o_frame_done
    );

endinterface : sp_draw_scheduler_if
`default_nettype wire

// File: rtl/sp_cmd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sp_cmd_fifo                                            |
// | Description : Synchronous command FIFO with flush and show-ahead     |
// |               head output. Push while full is honoured when a pop   |
// |               happens in the same cycle.                             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sp_cmd_fifo
    import sp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    input  wire logic    i_flush,
    input  wire logic    i_push,
    input  sp_cmd_t      i_data,
    input  wire logic    i_pop,
    output sp_cmd_t      o_data,
    output logic         o_empty,
    output logic         o_full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sp_cmd_t           r_mem [DEPTH];
    logic [c_AW:0]     r_wptr;
    logic [c_AW:0]     r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || i_pop);

    // Storage write; a flush cancels any push in the same cycle
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr[c_AW-1:0]] <= i_data;
        end
    end

    // Pointer update; flush empties the queue
    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rptr[c_AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

endmodule : sp_cmd_fifo
`default_nettype wire

// File: rtl/sp_draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sp_draw_scheduler                                      |
// | Description : Queues draw commands, fetches each texture, broadcasts |
// |               one ena pulse per command to the tile array, clears    |
// |               the array at frame start and reports frame completion. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sp_draw_scheduler
    import sp_pkg::*;
#(
    parameter int TEX_AW      = 10,
    parameter int TEX_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    sp_draw_scheduler_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(TEX_LATENCY + 1);
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(TEX_LATENCY);

    sp_state_t           r_state;
    sp_state_t           w_next;
    logic                r_in_frame;
    logic [c_CNT_W-1:0]  r_wait_cnt;

    // in-flight command fields
    logic [SP_X_W-1:0]   r_cmd_x;
    logic [SP_Z_W-1:0]   r_cmd_z;
    logic                r_cmd_last;

    // registered outputs
    logic                r_tex_rd;
    logic [TEX_AW-1:0]   r_tex_addr;
    logic                r_sp_reset_n;
    logic                r_sp_ena;
    logic [SP_TEX_W-1:0] r_sp_tex;
    logic [SP_X_W-1:0]   r_sp_x;
    logic [SP_Z_W-1:0]   r_sp_z;
    logic                r_frame_done;

    // FIFO hookup
    sp_cmd_t             w_push_cmd;
    sp_cmd_t             w_head;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_addr;

    assign w_ready = r_in_frame && !w_fifo_full && (r_state != ST_CLEAR) &&
                     !bus.i_frame_start;
    assign w_push  = bus.i_cmd_valid && w_ready;

    assign w_push_cmd.tex_addr = SP_ADDR_MAX_W'(bus.i_cmd_tex_addr);
    assign w_push_cmd.start_x  = bus.i_cmd_start_x;
    assign w_push_cmd.z        = bus.i_cmd_z;
    assign w_push_cmd.last     = bus.i_cmd_last;

    // Upper address bits of the record are not needed when TEX_AW is narrow
    assign w_unused_addr = ^w_head.tex_addr;

    sp_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (bus.i_frame_start),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and FIFO pop; ISSUE chains straight into the next fetch
    // so commands stream at one per TEX_LATENCY+2 cycles.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        if (bus.i_frame_start) begin
            w_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_in_frame && !w_fifo_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_FETCH;
                    end
                end
                ST_FETCH: w_next = ST_WAIT;
                ST_WAIT: begin
                    if (r_wait_cnt == c_LAT) begin
                        w_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_cmd_last) begin
                        w_next = ST_DONE;
                    end else if (r_in_frame && !w_fifo_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_FETCH;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_DONE:  w_next = ST_IDLE;
                ST_CLEAR: w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs; pulses are aligned with their state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_frame   <= 1'b0;
            r_wait_cnt   <= '0;
            r_cmd_x      <= '0;
            r_cmd_z      <= '0;
            r_cmd_last   <= 1'b0;
            r_tex_rd     <= 1'b0;
            r_tex_addr   <= '0;
            r_sp_reset_n <= 1'b0;
            r_sp_ena     <= 1'b0;
            r_sp_tex     <= '0;
            r_sp_x       <= '0;
            r_sp_z       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_tex_rd     <= (w_next == ST_FETCH);
            r_sp_ena     <= (w_next == ST_ISSUE);
            r_frame_done <= (w_next == ST_DONE);
            r_sp_reset_n <= (w_next != ST_CLEAR);

            if (bus.i_frame_start) begin
                r_in_frame <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_in_frame <= 1'b0;
            end

            if (w_pop) begin
                r_cmd_x    <= w_head.start_x;
                r_cmd_z    <= w_head.z;
                r_cmd_last <= w_head.last;
                r_tex_addr <= w_head.tex_addr[TEX_AW-1:0];
            end

            // Count WAIT cycles; data is valid on the TEX_LATENCY-th one
            if (r_state == ST_FETCH) begin
                r_wait_cnt <= c_CNT_W'(1);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            // Broadcast fields change only on entry to ISSUE
            if (w_next == ST_ISSUE) begin
                r_sp_tex <= bus.i_tex_data;
                r_sp_x   <= r_cmd_x;
                r_sp_z   <= r_cmd_z;
            end
        end
    end

    assign bus.o_cmd_ready       = w_ready;
    assign bus.o_tex_rd          = r_tex_rd;
    assign bus.o_tex_addr        = r_tex_addr;
    assign bus.o_sp_reset_n      = r_sp_reset_n;
    assign bus.o_sp_ena          = r_sp_ena;
    assign bus.o_sp_texture_data = r_sp_tex;
    assign bus.o_sp_start_x      = r_sp_x;
    assign bus.o_sp_z            = r_sp_z;
    assign bus.o_busy            = r_in_frame;
    assign bus.o_frame_done      = r_frame_done;

endmodule : sp_draw_scheduler
`default_nettype wire
